fetch_queue: RTL
================

Name: fetch_queue

Overview:
Parametrised instruction prefetch queue between memory space and the instruction decoder. It autonomously fetches sequential instruction words over a request/grant memory port and buffers them, with their addresses, in a DEPTH-entry FIFO. The decoder consumes words through a valid/ready handshake, and a redirect (branch/jump/call/reti) flushes the queue and restarts fetch at a new PC. It replaces direct PC-driven fetch through the MAB mux in the core pipeline.

Parameters:
SIZE, 16, data and address width in bits.
DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
clk  input  1  core clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset.
RST_VEC  input  SIZE  reset vector; loaded as the fetch PC in the BOOT state.
redirect  input  1  flush the queue and restart fetch at redirect_pc.
redirect_pc  input  SIZE  new fetch address; bit 0 is forced to 0.
fetch_req  output  1  memory read request.
fetch_addr  output  SIZE  word address for the request; held stable while fetch_req=1 and fetch_gnt=0.
fetch_gnt  input  1  arbiter grant; data-side accesses have priority.
fetch_rdata  input  SIZE  read data, valid in the cycle after a grant.
iw_valid  output  1  head word available.
iw_data  output  SIZE  head instruction word.
iw_pc  output  SIZE  address of the head word.
iw_ready  input  1  decoder accepts the head word.
level  output  $clog2(DEPTH+1)  number of FIFO entries.

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT; pc=0; FIFO emptied; fetch_req=0; fetch_addr=0; iw_valid=0; iw_data=0; iw_pc=0; level=0.
- State machine:
  - BOOT: for one cycle, pc <= {RST_VEC[SIZE-1:1],0}; then go to REQ. A redirect in BOOT takes priority over RST_VEC.
  - REQ: fetch_req=1 iff level<DEPTH, with fetch_addr=pc. On a cycle with fetch_req and fetch_gnt: pc<=pc+2 (wraps modulo 2^SIZE), go to RESP. Otherwise stay in REQ.
  - RESP: fetch_req=0. Push {pc_of_request, fetch_rdata} into the FIFO, then go to REQ.
  - DROP: fetch_req=0. Discard fetch_rdata, then go to REQ.
- At most one fetch is ever in flight. Throughput is 1 word per 2 cycles when grants are immediate.
- Full: no request is issued while level==DEPTH. A request is only issued with a free slot, so a RESP push can never overflow.
- Pop: occurs when iw_valid && iw_ready. Simultaneous push and pop leaves level unchanged.
- Empty: iw_valid=0. iw_data and iw_pc hold their last values and are don't-care for verification.
- redirect (highest priority, any state except reset):
  - Same cycle: FIFO cleared, level<=0, pc<={redirect_pc[SIZE-1:1],0}.
  - Any pop in that cycle is ignored; any push in that cycle (RESP) is discarded.
  - Next state:
    - REQ with a grant in the same cycle: go to DROP, because the old-address word is still in flight.
    - REQ without a grant, RESP, DROP, or BOOT: go to REQ.
  - iw_valid is 0 in the cycle after a redirect.
- Latency (macro undefined): fetch_rdata in RESP cycle t gives iw_valid at t+1.
- level is registered and reflects pushes and pops from the previous edge.

Optional Feature:
FETCH_BYPASS_EN
- Defined: in RESP with the FIFO empty and no redirect, iw_valid=1 combinationally in cycle t, with iw_data=fetch_rdata and iw_pc=the request address.
  - If iw_ready=1 in that cycle, the word is consumed and not written (level stays 0).
  - Otherwise it is pushed as normal.
- Undefined: no bypass path; iw_valid is driven purely from the FIFO.

Test Plan:
1. RST_VEC=0xC000, rst released, fetch_gnt=1, iw_ready=1 -> BOOT for 1 cycle; next cycle fetch_req=1 with fetch_addr=0xC000; then words appear with iw_pc 0xC000, 0xC002, 0xC004 in order.
2. iw_ready=0, fetch_gnt=1, rdata=addr^0xFFFF -> four pushes (0xC000..0xC006); level=4; fetch_req stays 0 indefinitely; iw_data=0x3FFF.
3. From full, iw_ready=1 for 1 cycle -> level 3; one new request at 0xC008; on its RESP cycle with iw_ready=1, the simultaneous push/pop keeps level=3.
4. redirect=1 with redirect_pc=0xE001 in a RESP cycle -> rdata discarded; level=0 next cycle; iw_valid=0; next request at fetch_addr=0xE000.
5. redirect=1 to 0xF000 in a REQ cycle where fetch_gnt=1 at 0xC004 -> DROP; 0xC004 data never appears on iw_data; the following request is at 0xF000.
6. fetch_gnt=0 for 3 cycles in REQ -> fetch_req=1 and fetch_addr unchanged for all 3 cycles; asserting rst mid-RESP clears level to 0 and iw_valid to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch over a request/grant port into a DEPTH-entry FIFO.
// Optional FETCH_BYPASS_EN forwards a response straight to the decoder when the FIFO is empty.
module fetch_queue #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SIZE-1:0]              RST_VEC,
    input  logic                         redirect,
    input  logic [SIZE-1:0]              redirect_pc,
    output logic                         fetch_req,
    output logic [SIZE-1:0]              fetch_addr,
    input  logic                         fetch_gnt,
    input  logic [SIZE-1:0]              fetch_rdata,
    output logic                         iw_valid,
    output logic [SIZE-1:0]              iw_data,
    output logic [SIZE-1:0]              iw_pc,
    input  logic                         iw_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);
    localparam logic [SIZE-1:0] ALIGN = {{(SIZE-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_RESP, S_DROP} state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   pc_q, pc_d;
    logic [SIZE-1:0]   req_pc_q, req_pc_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              fetch_req_q, fetch_req_d;
    logic [SIZE-1:0]   mem_data_q [DEPTH];
    logic [SIZE-1:0]   mem_data_d [DEPTH];
    logic [SIZE-1:0]   mem_pc_q   [DEPTH];
    logic [SIZE-1:0]   mem_pc_d   [DEPTH];

    logic fifo_valid;
    logic bypass;
    logic granted;
    logic push;
    logic pop;

    assign fifo_valid = (level_q != '0);
    assign granted    = (state_q == S_REQ) && fetch_req_q && fetch_gnt;

`ifdef FETCH_BYPASS_EN
    assign bypass = (state_q == S_RESP) && !fifo_valid && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign iw_valid   = fifo_valid || bypass;
    assign iw_data    = bypass ? fetch_rdata : mem_data_q[rd_ptr_q];
    assign iw_pc      = bypass ? req_pc_q    : mem_pc_q[rd_ptr_q];
    assign fetch_req  = fetch_req_q;
    assign fetch_addr = pc_q;
    assign level      = level_q;

    // Next-state, FIFO bookkeeping and request generation; redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_data_d = mem_data_q;
        mem_pc_d   = mem_pc_q;
        push       = 1'b0;
        pop        = 1'b0;

        case (state_q)
            S_BOOT: begin
                pc_d    = RST_VEC & ALIGN;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (granted) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + SIZE'(2);
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                push    = !(bypass && iw_ready);
                state_d = S_REQ;
            end
            S_DROP: state_d = S_REQ;
            default: state_d = S_REQ;
        endcase

        pop = fifo_valid && iw_ready;

        if (redirect) begin
            push     = 1'b0;
            pop      = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pc_d     = redirect_pc & ALIGN;
            // A word granted this cycle belongs to the old stream and must be dropped.
            state_d  = granted ? S_DROP : S_REQ;
            level_d  = '0;
        end else begin
            level_d = level_q + LW'(push) - LW'(pop);
        end

        if (push) begin
            mem_data_d[wr_ptr_q] = fetch_rdata;
            mem_pc_d[wr_ptr_q]   = req_pc_q;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        fetch_req_d = (state_d == S_REQ) && (level_d < LW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_BOOT;
            pc_q        <= '0;
            req_pc_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            fetch_req_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            fetch_req_q <= fetch_req_d;
            mem_data_q  <= mem_data_d;
            mem_pc_q    <= mem_pc_d;
        end
    end

endmodule
